// File: rtl/uart_core.sv
// uart_core: 16x oversampled UART with FIFO-buffered RX/TX, sticky error flags and hardware echo.
// uart_fifo is the first-word fall-through buffer used on both sides.
module uart_fifo #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count
);
   logic [W-1:0] mem [2**AW];
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
   logic        empty_q, empty_d, full_q, full_d, do_wr, do_rd;

   always_comb begin
      do_wr    = wr_en && !full_q;
      do_rd    = rd_en && !empty_q;
      wr_ptr_d = do_wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
      empty_d  = wr_ptr_d == rd_ptr_d;
      full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      count_d  = wr_ptr_d - rd_ptr_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   always_ff @(posedge clk)
      if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;

   assign rd_data = empty_q ? '0 : mem[rd_ptr_q[AW-1:0]];
   assign empty   = empty_q;
   assign full    = full_q;
   assign count   = count_q;
endmodule

module uart_core #(
   parameter int CLK_DIV   = 27,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int ADDR_W    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   output logic              tx,
   input  logic              echo_en,
   input  logic [7:0]        wr_data,
   input  logic              wr_en,
   output logic              tx_full,
   output logic [7:0]        rd_data,
   input  logic              rd_en,
   output logic              rx_empty,
   output logic [ADDR_W:0]   rx_count,
   output logic              frame_err,
   output logic              parity_err,
   output logic              overrun,
   input  logic              err_clr
);
   localparam int TW      = $clog2(CLK_DIV);
   localparam int BIT_CYC = 16 * CLK_DIV;
   localparam int CW      = $clog2(BIT_CYC);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               rx_state_q, rx_state_d, tx_state_q, tx_state_d;
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [3:0]           rx_os_q, rx_os_d;
   logic [2:0]           rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_bad_q, rx_bad_d, tx_par_q, tx_par_d;
   logic                 frame_err_q, frame_err_d, parity_err_q, parity_err_d, overrun_q, overrun_d;
   logic                 tick, rx_sample, rx_push, frame_set, par_set, tx_bit_end, tx_pop;
   logic                 echo_xfer, rxf_rd, txf_wr, rxf_empty, rxf_full, txf_empty, txf_full;
   logic [DATA_BITS-1:0] rxf_dout, txf_din, txf_dout;
   logic [ADDR_W:0]      unused_tx_count;

   assign tick       = tick_cnt_q == TW'(CLK_DIV - 1);
   assign tx_bit_end = tx_cnt_q == CW'(BIT_CYC - 1);

   // Echo moves one byte per cycle RX->TX; host FIFO strobes are ignored while echo is on.
   always_comb begin
      tick_cnt_d   = tick ? '0 : tick_cnt_q + TW'(1);
      rx_s1_d      = rx;
      rx_s2_d      = rx_s1_q;
      echo_xfer    = echo_en && !rxf_empty && !txf_full;
      rxf_rd       = echo_en ? echo_xfer : rd_en;
      txf_wr       = echo_en ? echo_xfer : wr_en;
      txf_din      = echo_en ? rxf_dout : wr_data[DATA_BITS-1:0];
      frame_err_d  = frame_set || (frame_err_q && !err_clr);
      parity_err_d = par_set || (parity_err_q && !err_clr);
      overrun_d    = (rx_push && rxf_full) || (overrun_q && !err_clr);
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_os_d    = tick ? rx_os_q + 4'd1 : rx_os_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_bad_d   = rx_bad_q;
      rx_push    = 1'b0;
      frame_set  = 1'b0;
      par_set    = 1'b0;
      rx_sample  = tick && rx_os_q == 4'd15;
      case (rx_state_q)
         S_IDLE: begin
            rx_os_d = '0;
            if (!rx_s2_q) rx_state_d = S_START;
         end
         S_START: if (tick && rx_os_q == 4'd7) begin
            rx_os_d    = '0;
            rx_bit_d   = '0;
            rx_bad_d   = 1'b0;
            rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
         end
         S_DATA: if (rx_sample) begin
            rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'(DATA_BITS - 1)) rx_state_d = PARITY != 0 ? S_PARITY : S_STOP;
         end
         S_PARITY: if (rx_sample) begin
            par_set    = rx_s2_q != ((^rx_sh_q) ^ (PARITY == 1));
            rx_bad_d   = par_set;
            rx_state_d = S_STOP;
         end
         S_STOP: if (rx_sample) begin
            frame_set  = !rx_s2_q;
            rx_push    = rx_s2_q && !rx_bad_q;
            rx_state_d = S_IDLE;
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   // TX times bits with its own cycle counter so every bit is exactly 16 ticks long.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            tx_cnt_d = '0;
            tx_pop   = !txf_empty;
         end
         S_START: if (tx_bit_end) begin
            tx_state_d = S_DATA;
            tx_bit_d   = '0;
         end
         S_DATA: if (tx_bit_end) begin
            tx_sh_d  = tx_sh_q >> 1;
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'(DATA_BITS - 1)) begin
               tx_bit_d   = '0;
               tx_state_d = PARITY != 0 ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: if (tx_bit_end) tx_state_d = S_STOP;
         S_STOP: if (tx_bit_end) begin
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'(STOP_BITS - 1)) begin
               tx_pop     = !txf_empty;
               tx_state_d = S_IDLE;
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
      if (tx_pop) begin
         tx_state_d = S_START;
         tx_sh_d    = txf_dout;
         tx_par_d   = (^txf_dout) ^ (PARITY == 1);
         tx_bit_d   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt_q   <= '0;
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_state_q   <= S_IDLE;
         rx_os_q      <= '0;
         rx_bit_q     <= '0;
         rx_sh_q      <= '0;
         rx_bad_q     <= 1'b0;
         tx_state_q   <= S_IDLE;
         tx_cnt_q     <= '0;
         tx_bit_q     <= '0;
         tx_sh_q      <= '0;
         tx_par_q     <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         rx_s1_q      <= rx_s1_d;
         rx_s2_q      <= rx_s2_d;
         rx_state_q   <= rx_state_d;
         rx_os_q      <= rx_os_d;
         rx_bit_q     <= rx_bit_d;
         rx_sh_q      <= rx_sh_d;
         rx_bad_q     <= rx_bad_d;
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_sh_q      <= tx_sh_d;
         tx_par_q     <= tx_par_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   uart_fifo #(.W(DATA_BITS), .AW(ADDR_W)) u_rx_fifo (
      .clk(clk), .reset(reset), .wr_en(rx_push), .wr_data(rx_sh_q), .rd_en(rxf_rd),
      .rd_data(rxf_dout), .empty(rxf_empty), .full(rxf_full), .count(rx_count)
   );

   uart_fifo #(.W(DATA_BITS), .AW(ADDR_W)) u_tx_fifo (
      .clk(clk), .reset(reset), .wr_en(txf_wr), .wr_data(txf_din), .rd_en(tx_pop),
      .rd_data(txf_dout), .empty(txf_empty), .full(txf_full), .count(unused_tx_count)
   );

   assign tx         = tx_state_q == S_START ? 1'b0 : tx_state_q == S_DATA ? tx_sh_q[0] :
                       tx_state_q == S_PARITY ? tx_par_q : 1'b1;
   assign tx_full    = txf_full;
   assign rx_empty   = rxf_empty;
   assign rd_data    = 8'(rxf_dout);
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed scoreboard bench for uart_core with an 8N1 and an 8E1 instance at CLK_DIV=4.
module tb_uart_core;
   localparam int BIT = 64;
   logic clk = 0, reset = 1, echo_en = 0, wr_en = 0, rd_en = 0, rd_en_e = 0, err_clr = 0;
   logic rx_n = 1, rx_e = 1;
   logic [7:0] wr_data = 0;
   logic tx_n, tx_e, tx_full_n, tx_full_e, rx_empty_n, rx_empty_e;
   logic [7:0] rd_data_n, rd_data_e;
   logic [4:0] rx_count_n, rx_count_e;
   logic fe_n, fe_e, pe_n, pe_e, ov_n, ov_e;
   int checks = 0, failures = 0, unexp = 0;
   logic [7:0] rx_exp[$], tx_exp[$];

   always #5 clk = ~clk;

   uart_core #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .ADDR_W(4)) u_n (
      .clk(clk), .reset(reset), .rx(rx_n), .tx(tx_n), .echo_en(echo_en), .wr_data(wr_data),
      .wr_en(wr_en), .tx_full(tx_full_n), .rd_data(rd_data_n), .rd_en(rd_en), .rx_empty(rx_empty_n),
      .rx_count(rx_count_n), .frame_err(fe_n), .parity_err(pe_n), .overrun(ov_n), .err_clr(err_clr)
   );

   uart_core #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .ADDR_W(4)) u_e (
      .clk(clk), .reset(reset), .rx(rx_e), .tx(tx_e), .echo_en(1'b0), .wr_data(8'h00),
      .wr_en(1'b0), .tx_full(tx_full_e), .rd_data(rd_data_e), .rd_en(rd_en_e), .rx_empty(rx_empty_e),
      .rx_count(rx_count_e), .frame_err(fe_e), .parity_err(pe_e), .overrun(ov_e), .err_clr(err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input bit sel, input logic [7:0] d, input bit par_en, input logic par, input logic stp);
      logic [10:0] f;
      int n;
      n = par_en ? 11 : 10;
      f = par_en ? {stp, par, d, 1'b0} : {1'b1, stp, d, 1'b0};
      for (int i = 0; i < n; i++) begin
         if (sel) rx_e = f[i]; else rx_n = f[i];
         repeat ((i == n - 1 && !stp) ? 40 : BIT) @(negedge clk);
      end
      rx_e = 1;
      rx_n = 1;
   endtask

   task automatic rd_chk(input bit sel, input string tag);
      chk(tag, sel ? rd_data_e : rd_data_n, rx_exp.pop_front());
      if (sel) rd_en_e = 1; else rd_en = 1;
      @(negedge clk);
      rd_en = 0;
      rd_en_e = 0;
   endtask

   task automatic clear_errs();
      err_clr = 1;
      @(negedge clk);
      err_clr = 0;
   endtask

   // Serial monitor on the 8N1 TX line: decodes each frame at bit centres and scores it.
   initial begin : mon
      logic [9:0] bits;
      logic ab;
      forever begin
         @(negedge clk);
         if (!reset && tx_n === 1'b0) begin
            bits = '0;
            ab = 0;
            for (int k = 1; k <= 9 * BIT + BIT / 2; k++) begin
               @(negedge clk);
               ab |= reset;
               if (k % BIT == BIT / 2) bits[k / BIT] = tx_n;
            end
            if (!ab) begin
               if (tx_exp.size() > 0) chk("tx_frame", {22'd0, bits}, {22'd0, 1'b1, tx_exp.pop_front(), 1'b0});
               else unexp++;
            end
         end
      end
   end

   initial begin
      int lows, c, errs;
      logic [9:0] pat;
      repeat (3) @(negedge clk);
      chk("rst_tx", {tx_n, tx_e}, 2'b11);
      chk("rst_tx_full", {tx_full_n, tx_full_e}, 0);
      chk("rst_rx_empty", {rx_empty_n, rx_empty_e}, 2'b11);
      chk("rst_rx_count", {rx_count_n, rx_count_e}, 0);
      chk("rst_rd_data", rd_data_n, 0);
      chk("rst_flags", {fe_n, pe_n, ov_n, fe_e, pe_e, ov_e}, 0);
      reset = 0;
      lows = 0;
      repeat (200) begin
         @(negedge clk);
         lows += int'(tx_n !== 1'b1);
      end
      chk("idle_tx_low_cycles", lows, 0);
      chk("idle_rx", {rx_empty_n, rx_count_n}, {1'b1, 5'd0});
      chk("idle_flags", {fe_n, pe_n, ov_n}, 0);

      wr_data = 8'hA5;
      wr_en = 1;
      tx_exp.push_back(8'hA5);
      @(negedge clk);
      wr_en = 0;
      c = 1;
      while (tx_n !== 1'b0 && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("tx_start_latency", c, 2);
      pat = {1'b1, 8'hA5, 1'b0};
      errs = 0;
      for (int k = 0; k < 10 * BIT; k++) begin
         errs += int'(tx_n !== pat[k / BIT]);
         @(negedge clk);
      end
      chk("tx_wave_errs", errs, 0);
      chk("tx_after_frame", tx_n, 1);

      send(1, 8'h3C, 1, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      chk("par_err_set", pe_e, 1);
      chk("par_rx_empty", rx_empty_e, 1);
      clear_errs();
      chk("par_err_clr", pe_e, 0);
      rx_exp.push_back(8'h3C);
      send(1, 8'h3C, 1, 1'b0, 1'b1);
      c = 0;
      while (rx_empty_e && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk("par_good_arrive", rx_empty_e, 0);
      chk("par_count", rx_count_e, 1);
      chk("par_good_no_err", pe_e, 0);
      rd_chk(1, "par_rd_data");
      chk("par_drained", rx_empty_e, 1);

      send(0, 8'h55, 0, 1'b0, 1'b0);
      repeat (100) @(negedge clk);
      chk("frame_err_set", fe_n, 1);
      chk("frame_discard", rx_empty_n, 1);
      clear_errs();
      chk("frame_err_clr", fe_n, 0);
      rx_n = 0;
      repeat (3) @(negedge clk);
      rx_n = 1;
      repeat (300) @(negedge clk);
      chk("glitch_empty", rx_empty_n, 1);
      chk("glitch_flags", {fe_n, pe_n, ov_n}, 0);

      for (int i = 0; i < 17; i++) begin
         if (i < 16) rx_exp.push_back(8'(i * 13 + 7));
         send(0, 8'(i * 13 + 7), 0, 1'b0, 1'b1);
      end
      repeat (5) @(negedge clk);
      chk("ovr_count", rx_count_n, 16);
      chk("ovr_flag", ov_n, 1);
      rd_chk(0, "ovr_first_byte");
      clear_errs();
      chk("ovr_clr", ov_n, 0);
      chk("ovr_count_after_rd", rx_count_n, 15);
      for (int i = 0; i < 15; i++) rd_chk(0, "ovr_drain");
      chk("ovr_empty", rx_empty_n, 1);

      echo_en = 1;
      for (int i = 0; i < 3; i++) begin
         tx_exp.push_back(8'(8'h41 + i));
         send(0, 8'(8'h41 + i), 0, 1'b0, 1'b1);
         if (i == 0) begin
            wr_data = 8'hFF;
            wr_en = 1;
            rd_en = 1;
            @(negedge clk);
            wr_en = 0;
            rd_en = 0;
         end
      end
      c = 0;
      while (tx_exp.size() != 0 && c < 3000) begin
         @(negedge clk);
         c++;
      end
      chk("echo_frames_in_time", c < 3000, 1);
      repeat (700) @(negedge clk);
      chk("echo_rx_empty", rx_empty_n, 1);
      chk("tx_unexpected_frames", unexp, 0);
      echo_en = 0;

      wr_data = 8'h5A;
      wr_en = 1;
      @(negedge clk);
      wr_en = 0;
      c = 0;
      while (tx_n !== 1'b0 && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("rst_mid_started", tx_n, 0);
      repeat (100) @(negedge clk);
      chk("rst_mid_tx_low_bit", tx_n, 0);
      #2 reset = 1;
      #1 chk("rst_async_tx", tx_n, 1);
      repeat (2) @(negedge clk);
      reset = 0;
      lows = 0;
      repeat (800) begin
         @(negedge clk);
         lows += int'(tx_n !== 1'b1);
      end
      chk("rst_mid_quiet", lows, 0);
      chk("rst_mid_tx_full", tx_full_n, 0);
      chk("tx_exp_left", tx_exp.size(), 0);
      chk("tx_unexpected_final", unexp, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_core.md
# uart_core

Parametrised UART core with a 16x oversampling receiver, a transmitter, a FIFO on each side, frame/parity/overrun error reporting and a hardware echo mode. It is the successor to the fixed 8N1 loopback top: the host side sees two FIFO ports and the serial side connects straight to the board pins. Frame format, baud divisor and FIFO depth are set at elaboration.

## Interface
- CLK_DIV, 27: clk cycles per oversampling tick (bit period = 16*CLK_DIV); legal >= 2
- DATA_BITS, 8: data bits per frame, 5..8, LSB first
- PARITY, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: 1 or 2
- ADDR_W, 4: FIFO depth = 2**ADDR_W, both FIFOs

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- rx  in  1  serial input, idle high; 2-flop synchronised internally
- tx  out  1  serial output, idle high
- echo_en  in  1  1 = route received bytes to the TX FIFO in hardware
- wr_data  in  8  byte to transmit; bits above DATA_BITS ignored
- wr_en  in  1  push wr_data into the TX FIFO
- tx_full  out  1  TX FIFO full
- rd_data  out  8  head of the RX FIFO (show-ahead), zero-extended
- rd_en  in  1  pop the RX FIFO
- rx_empty  out  1  RX FIFO empty
- rx_count  out  ADDR_W+1  RX FIFO occupancy
- frame_err  out  1  sticky: stop bit sampled low
- parity_err  out  1  sticky: parity mismatch
- overrun  out  1  sticky: byte received while RX FIFO full
- err_clr  in  1  clears the three sticky flags

## Operation
- Tick generator: a counter 0..CLK_DIV-1 runs freely and asserts a one-cycle tick at terminal count.
- RX FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a synchronised low on rx.
  - START: at tick 7, if rx is still low go to DATA; otherwise the event is a glitch and the FSM returns to IDLE.
  - Each following bit is sampled 16 ticks after the previous sample.
  - DATA shifts in DATA_BITS bits.
  - PARITY is skipped when PARITY=0.
  - STOP samples the first stop bit only. A low sample sets frame_err and the byte is discarded.
  - A parity mismatch sets parity_err and the byte is discarded.
  - A good byte is pushed into the RX FIFO. If the FIFO is full the byte is dropped, overrun is set, and FIFO contents are unchanged.
- TX FSM states are IDLE, START, DATA, PARITY, STOP.
  - Each bit lasts 16 ticks.
  - In IDLE the FSM pops the TX FIFO when it is non-empty and starts a frame on the next cycle.
  - It sends start(0), the data bits LSB first, parity if enabled, then STOP_BITS ones.
  - After the last stop bit it returns to IDLE. If the FIFO is non-empty it starts the next frame back-to-back with no extra idle bit.
- FIFOs are synchronous with first-word fall-through.
  - Pointers are ADDR_W+1 bits; full/empty are derived from the MSB and the remaining bits.
  - Pointer wrap-around is natural.
  - wr_en while full and rd_en while empty are ignored, with no state change.
  - Simultaneous push and pop on a non-empty, non-full FIFO keeps occupancy constant.
- Echo mode (echo_en=1):
  - Whenever the RX FIFO is not empty and the TX FIFO is not full, the core pops RX and pushes the same byte into TX in the same cycle.
  - Host wr_en and rd_en are ignored.
  - Changing echo_en affects only the next transfer decision; a byte is never duplicated or lost.
- The sticky flags hold until err_clr or reset. If a set condition coincides with err_clr, the set wins.

## Timing
- Reset values: tx=1, tx_full=0, rx_empty=1, rx_count=0, rd_data=0, all error flags 0, both FSMs in IDLE, tick counter 0.
- Reset asserted mid-frame aborts the frame immediately; tx returns high in the same cycle (asynchronous).
- Registered outputs: rx_empty, tx_full, rx_count and the error flags update 1 cycle after the causing event.
- rd_data shows the next entry 1 cycle after rd_en.
- RX latency: from the stop-bit sample to rx_empty falling is 1 cycle.
- TX latency: wr_en into an empty TX FIFO with the FSM idle gives tx falling after 2 cycles.
- Frame length: 16*CLK_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
- Echo latency: from RX push to TX push is 1 cycle when TX has room.

## Test plan
- Reset, then drive nothing -> tx=1 continuously, rx_empty=1, rx_count=0, all flags 0.
- CLK_DIV=4, 8N1; write 0xA5 -> tx low 64 cycles, then bits 1,0,1,0,0,1,0,1 of 64 cycles each, then high; total 640 cycles.
- Drive serial 0x3C on rx, even parity with a wrong parity bit -> parity_err=1, rx_empty stays 1. Repeat with a correct bit -> rd_data=0x3C, rx_count=1.
- Send 17 bytes with ADDR_W=4 and no reads -> rx_count=16, overrun=1, first read returns byte 0. Assert err_clr -> overrun=0.
- Stop bit driven low on byte 0x55 -> frame_err=1, byte discarded. A 3-clk low glitch on an idle rx -> no byte, no flag.
- echo_en=1; receive 0x41, 0x42, 0x43 -> tx emits the same three frames in order, rx_empty=1 at the end. Host wr_en of 0xFF during echo is never transmitted.
